jtag_dtm_param: RTL and testbench
=================================

Name: jtag_dtm_param

Overview:
Parametrised second-generation JTAG Debug Transport Module for the RISC-V debug path, driven by the existing TAP controller's capture/shift/update strobes and IR value.
Implements IDCODE, DTMCS, DMI and BYPASS data registers.
Adds a decoupled DMI request/response handshake, sticky busy/failed status, and dmireset/dmihardreset support.
Width, IR length, abits, idle hint and IDCODE are configurable.

Parameters:
IR_WIDTH, 5, TAP instruction register width
ABITS, 7, DMI address width; DMI scan length = ABITS+34
IDLE_CYCLES, 1, value reported in dtmcs.idle (0-7)
IDCODE_VALUE, 32'h1DEAD3FF, captured in IDCODE; bit0 must be 1
IR_IDCODE / IR_DTMCS / IR_DMI, 1 / 'h10 / 'h11, instruction encodings; any other IR selects BYPASS

Ports:
clk  in  1  system clock; TAP strobes are synchronous single-cycle pulses on clk
rst  in  1  asynchronous, active-high reset
tdi  in  1  serial data in
tdo  out  1  serial data out, combinational from selected register LSB
capture_dr / shift_dr / update_dr  in  1 each  TAP state strobes
ir_out  in  IR_WIDTH  current instruction
dmi_req_valid  out  1  request to DM
dmi_req_ready  in  1  DM accepts request
dmi_req_addr  out  ABITS  request address
dmi_req_data  out  32  write data
dmi_req_op  out  2  1=read, 2=write
dmi_rsp_valid  in  1  DM response available
dmi_rsp_ready  out  1  DTM accepts response
dmi_rsp_data  in  32  read data
dmi_rsp_resp  in  2  0=success, 2=failed, 3=busy
dmi_hard_reset  out  1  one-cycle pulse to DM on dmihardreset
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): all shift registers 0 except IDCODE shift = IDCODE_VALUE; state IDLE; sticky=0; rdata_q=0; addr_q=0; all DMI outputs 0; dmi_hard_reset=0; tdo follows selected register.
- DTMCS value: [3:0]=1, [9:4]=ABITS, [11:10]=sticky, [14:12]=IDLE_CYCLES, others 0. With defaults this is 0x00001071.
- FSM IDLE -> REQ -> RSP -> IDLE:
  - REQ: dmi_req_valid=1 with addr/data/op held stable; advance to RSP on the cycle valid&&ready.
  - RSP: dmi_rsp_ready=1; on rsp_valid, latch rdata_q = rsp_data and go to IDLE.
  - If sticky==0: resp 2 sets sticky=2; resp 3 sets sticky=3.
- Capture DMI: shift = {addr_q, rdata_q, status}.
  - If state != IDLE, status=3 and sticky becomes 3 if it was 0.
  - Otherwise status = sticky.
- Shift: shift in tdi at MSB; tdo = shift[0]. DMI length ABITS+34, IDCODE/DTMCS 32, BYPASS 1 (capture 0).
- Update DMI: accepted only if state==IDLE and sticky==0 and op in {1,2}.
  - On accept: latch addr_q, data, op and go to REQ next cycle.
  - If state != IDLE: sticky=3 and the op is dropped.
  - If sticky != 0, or op is 0 or 3: ignored.
- Update DTMCS: shift bit16 (dmireset) clears sticky. Bit17 (dmihardreset) clears sticky, forces IDLE, deasserts req_valid/rsp_ready next cycle, and pulses dmi_hard_reset for 1 cycle.
- If dmihardreset coincides with a handshake, the hard reset wins and the response is discarded.
- Capture and update in the same cycle cannot occur; if a strobe arrives while ir_out matches no register, BYPASS is used.

Decomposition:
- jtag_dmi_pkg gains: dmi_op_e, dmi_resp_e, dtm_state_e, DTMCS field offset constants, and DTMCS_VERSION.
- One natural sub-module: jtag_dtm_dmi_fsm (request/response FSM plus sticky logic), leaving the scan muxing in the top level.

Test Plan:
- Reset, IR=1, 32-bit DR scan -> tdo yields 0x1DEAD3FF LSB first.
- IR=0x10 scan -> 0x00001071. Writing 0x00010000 clears sticky; reading back gives 0x00001071.
- DMI write addr 0x10, data 0x1, op 2 -> request seen with ready held low 3 cycles, fields stable. Then read 0x11 with DM rsp_data 0xDEADBEEF, resp 0 -> next capture = {0x11, 0xDEADBEEF, 0}.
- Scan DMI while DM withholds rsp_valid -> captured status 3, new op not issued, dtmcs[11:10]=3. dmireset -> status 0 and a subsequent op is accepted.
- DM returns resp 2 -> next capture status 2; following op ignored until dmireset.
- dmihardreset while in REQ -> req_valid low next cycle, dmi_hard_reset high for exactly 1 cycle, state IDLE. Also assert rst mid-RSP -> all outputs 0 immediately.

Source files
------------

// File: rtl/jtag_dmi_pkg.sv
// jtag_dmi_pkg: shared DMI/DTM types, DTMCS field layout and DTMCS word builder
package jtag_dmi_pkg;
    typedef enum logic [1:0] {OP_NOP = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2, OP_RSVD = 2'd3} dmi_op_e;
    typedef enum logic [1:0] {RESP_OK = 2'd0, RESP_RSVD = 2'd1, RESP_FAILED = 2'd2, RESP_BUSY = 2'd3} dmi_resp_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RSP = 2'd2} dtm_state_e;
    localparam int DTMCS_VERSION_LSB = 0;
    localparam int DTMCS_ABITS_LSB = 4;
    localparam int DTMCS_STAT_LSB = 10;
    localparam int DTMCS_IDLE_LSB = 12;
    localparam int DTMCS_DMIRESET = 16;
    localparam int DTMCS_DMIHARDRESET = 17;
    localparam logic [3:0] DTMCS_VERSION = 4'd1;

    function automatic logic [31:0] dtmcs_word(input int abits, input logic [1:0] stat, input int idle);
        logic [31:0] w;
        w = '0;
        w[DTMCS_VERSION_LSB +: 4] = DTMCS_VERSION;
        w[DTMCS_ABITS_LSB +: 6] = 6'(abits);
        w[DTMCS_STAT_LSB +: 2] = stat;
        w[DTMCS_IDLE_LSB +: 3] = 3'(idle);
        return w;
    endfunction
endpackage

// File: rtl/jtag_dtm_dmi_fsm.sv
// jtag_dtm_dmi_fsm: DMI request/response handshake FSM with sticky error status
module jtag_dtm_dmi_fsm
    import jtag_dmi_pkg::*;
#(
    parameter int ABITS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_dmi,
    input  logic             upd_dmi,
    input  logic [ABITS-1:0] upd_addr,
    input  logic [31:0]      upd_data,
    input  logic [1:0]       upd_op,
    input  logic             dmireset,
    input  logic             hardreset,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [ABITS-1:0] req_addr,
    output logic [31:0]      req_data,
    output logic [1:0]       req_op,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [31:0]      rsp_data,
    input  logic [1:0]       rsp_resp,
    output logic             hard_pulse,
    output logic             busy,
    output logic [1:0]       sticky,
    output logic [31:0]      rdata_q
);
    dtm_state_e state, state_d;
    logic [1:0] sticky_d;
    logic accept, rsp_hs;
    assign accept = upd_dmi && state == ST_IDLE && sticky == 2'd0 && (upd_op == OP_READ || upd_op == OP_WRITE);
    assign rsp_hs = state == ST_RSP && rsp_valid && !hardreset;
    assign req_valid = state == ST_REQ;
    assign rsp_ready = state == ST_RSP;
    assign busy = state != ST_IDLE;
    always_comb begin
        state_d = hardreset ? ST_IDLE :
                  accept ? ST_REQ :
                  (state == ST_REQ && req_ready) ? ST_RSP :
                  rsp_hs ? ST_IDLE : state;
        sticky_d = (hardreset || dmireset) ? 2'd0 :
                   (upd_dmi && busy) ? 2'd3 :
                   (sticky != 2'd0) ? sticky :
                   ((cap_dmi && busy) || (rsp_hs && rsp_resp == RESP_BUSY)) ? 2'd3 :
                   (rsp_hs && rsp_resp == RESP_FAILED) ? 2'd2 : sticky;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sticky <= '0;
            req_addr <= '0;
            req_data <= '0;
            req_op <= '0;
            rdata_q <= '0;
            hard_pulse <= 1'b0;
        end else begin
            state <= state_d;
            sticky <= sticky_d;
            hard_pulse <= hardreset;
            if (accept) begin
                req_addr <= upd_addr;
                req_data <= upd_data;
                req_op <= upd_op;
            end
            if (rsp_hs) rdata_q <= rsp_data;
        end
    end
endmodule

// File: rtl/jtag_dtm_param.sv
// jtag_dtm_param: RISC-V JTAG DTM with IDCODE/DTMCS/DMI/BYPASS scan registers
module jtag_dtm_param
    import jtag_dmi_pkg::*;
#(
    parameter int                  IR_WIDTH     = 5,
    parameter int                  ABITS        = 7,
    parameter int                  IDLE_CYCLES  = 1,
    parameter logic [31:0]         IDCODE_VALUE = 32'h1DEAD3FF,
    parameter logic [IR_WIDTH-1:0] IR_IDCODE    = IR_WIDTH'('h01),
    parameter logic [IR_WIDTH-1:0] IR_DTMCS     = IR_WIDTH'('h10),
    parameter logic [IR_WIDTH-1:0] IR_DMI       = IR_WIDTH'('h11)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tdi,
    output logic                tdo,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                dmi_req_valid,
    input  logic                dmi_req_ready,
    output logic [ABITS-1:0]    dmi_req_addr,
    output logic [31:0]         dmi_req_data,
    output logic [1:0]          dmi_req_op,
    input  logic                dmi_rsp_valid,
    output logic                dmi_rsp_ready,
    input  logic [31:0]         dmi_rsp_data,
    input  logic [1:0]          dmi_rsp_resp,
    output logic                dmi_hard_reset,
    output logic                busy
);
    localparam int DMI_LEN = ABITS + 34;
    logic [31:0] idcode_sr, dtmcs_sr, rdata_q;
    logic [DMI_LEN-1:0] dmi_sr;
    logic bypass_sr, sel_id, sel_cs, sel_dmi;
    logic [1:0] sticky, dmi_status;
    assign sel_id = ir_out == IR_IDCODE;
    assign sel_cs = ir_out == IR_DTMCS;
    assign sel_dmi = ir_out == IR_DMI;
    assign dmi_status = busy ? 2'(RESP_BUSY) : sticky;
    assign tdo = sel_id ? idcode_sr[0] : sel_cs ? dtmcs_sr[0] : sel_dmi ? dmi_sr[0] : bypass_sr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idcode_sr <= IDCODE_VALUE;
            dtmcs_sr <= '0;
            dmi_sr <= '0;
            bypass_sr <= 1'b0;
        end else if (capture_dr) begin
            if (sel_id) idcode_sr <= IDCODE_VALUE;
            else if (sel_cs) dtmcs_sr <= dtmcs_word(ABITS, sticky, IDLE_CYCLES);
            else if (sel_dmi) dmi_sr <= {dmi_req_addr_q(), rdata_q, dmi_status};
            else bypass_sr <= 1'b0;
        end else if (shift_dr) begin
            if (sel_id) idcode_sr <= {tdi, idcode_sr[31:1]};
            else if (sel_cs) dtmcs_sr <= {tdi, dtmcs_sr[31:1]};
            else if (sel_dmi) dmi_sr <= {tdi, dmi_sr[DMI_LEN-1:1]};
            else bypass_sr <= tdi;
        end
    end
    function automatic logic [ABITS-1:0] dmi_req_addr_q();
        return dmi_req_addr;
    endfunction
    jtag_dtm_dmi_fsm #(.ABITS(ABITS)) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .cap_dmi    (capture_dr && sel_dmi),
        .upd_dmi    (update_dr && sel_dmi),
        .upd_addr   (dmi_sr[DMI_LEN-1:34]),
        .upd_data   (dmi_sr[33:2]),
        .upd_op     (dmi_sr[1:0]),
        .dmireset   (update_dr && sel_cs && dtmcs_sr[DTMCS_DMIRESET]),
        .hardreset  (update_dr && sel_cs && dtmcs_sr[DTMCS_DMIHARDRESET]),
        .req_valid  (dmi_req_valid),
        .req_ready  (dmi_req_ready),
        .req_addr   (dmi_req_addr),
        .req_data   (dmi_req_data),
        .req_op     (dmi_req_op),
        .rsp_valid  (dmi_rsp_valid),
        .rsp_ready  (dmi_rsp_ready),
        .rsp_data   (dmi_rsp_data),
        .rsp_resp   (dmi_rsp_resp),
        .hard_pulse (dmi_hard_reset),
        .busy       (busy),
        .sticky     (sticky),
        .rdata_q    (rdata_q)
    );
endmodule

// File: tb/tb_jtag_dtm_param.sv
// tb_jtag_dtm_param: directed scan/handshake vectors for jtag_dtm_param
module tb_jtag_dtm_param;
    logic clk = 1'b0, rst = 1'b1, tdi = 1'b0, tdo;
    logic capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
    logic [4:0] ir_out = 5'h00;
    logic dmi_req_valid, dmi_req_ready = 1'b0, dmi_rsp_ready, dmi_rsp_valid = 1'b0;
    logic [6:0] dmi_req_addr;
    logic [31:0] dmi_req_data, dmi_rsp_data = 32'h0;
    logic [1:0] dmi_req_op, dmi_rsp_resp = 2'd0;
    logic dmi_hard_reset, busy;
    int total = 0, bad = 0;
    logic [63:0] d;

    jtag_dtm_param dut (
        .clk(clk), .rst(rst), .tdi(tdi), .tdo(tdo),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr), .ir_out(ir_out),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req_addr(dmi_req_addr),
        .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op), .dmi_rsp_valid(dmi_rsp_valid),
        .dmi_rsp_ready(dmi_rsp_ready), .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_resp(dmi_rsp_resp),
        .dmi_hard_reset(dmi_hard_reset), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic scan_dr(input logic [4:0] ir, input int len, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        ir_out = ir;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr = 1'b1;
        for (int i = 0; i < len; i++) begin
            dout[i] = tdo;
            tdi = din[i];
            tick();
        end
        shift_dr = 1'b0;
        tdi = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] v, input logic [1:0] s);
        return 64'({a, v, s});
    endfunction

    task automatic dm_accept();
        dmi_req_ready = 1'b1;
        tick();
        dmi_req_ready = 1'b0;
    endtask

    task automatic dm_respond(input logic [31:0] rd, input logic [1:0] rs);
        dmi_rsp_valid = 1'b1;
        dmi_rsp_data = rd;
        dmi_rsp_resp = rs;
        tick();
        dmi_rsp_valid = 1'b0;
        dmi_rsp_data = '0;
        dmi_rsp_resp = '0;
    endtask

    initial begin
        tick();
        chk("rst_outs", 64'({dmi_req_valid, dmi_rsp_ready, busy, dmi_hard_reset, dmi_req_addr, dmi_req_data, dmi_req_op}), 64'h0);
        chk("rst_tdo_bypass", 64'(tdo), 64'h0);
        ir_out = 5'h01;
        #1;
        chk("rst_tdo_idcode", 64'(tdo), 64'h1);
        tick();
        rst = 1'b0;
        tick();

        scan_dr(5'h01, 32, 64'h0, d);
        chk("idcode", d, 64'h1DEAD3FF);
        scan_dr(5'h1F, 2, 64'h3, d);
        chk("bypass", d, 64'h2);
        scan_dr(5'h10, 32, 64'h0, d);
        chk("dtmcs", d, 64'h1071);
        scan_dr(5'h10, 32, 64'h10000, d);
        chk("dtmcs_clr", d, 64'h1071);
        scan_dr(5'h10, 32, 64'h0, d);
        chk("dtmcs_after_clr", d, 64'h1071);

        scan_dr(5'h11, 41, dmi_word(7'h10, 32'h1, 2'd2), d);
        chk("dmi_cap0", d, 64'h0);
        for (int i = 0; i < 3; i++) begin
            chk("req_hold", 64'({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}), 64'({1'b1, 7'h10, 32'h1, 2'd2}));
            tick();
        end
        dm_accept();
        chk("rsp_phase", 64'({dmi_req_valid, dmi_rsp_ready, busy}), 64'b011);
        dm_respond(32'h0, 2'd0);
        chk("wr_done", 64'({busy, dmi_rsp_ready}), 64'h0);

        scan_dr(5'h11, 41, dmi_word(7'h11, 32'h0, 2'd1), d);
        chk("dmi_cap_wr", d, dmi_word(7'h10, 32'h0, 2'd0));
        chk("rd_req", 64'({dmi_req_valid, dmi_req_addr, dmi_req_op}), 64'({1'b1, 7'h11, 2'd1}));
        dm_accept();
        dm_respond(32'hDEADBEEF, 2'd0);
        scan_dr(5'h11, 41, 64'h0, d);
        chk("dmi_cap_rd", d, dmi_word(7'h11, 32'hDEADBEEF, 2'd0));
        chk("nop_ignored", 64'(busy), 64'h0);

        scan_dr(5'h11, 41, dmi_word(7'h05, 32'h0, 2'd1), d);
        chk("rd5_cap", d, dmi_word(7'h11, 32'hDEADBEEF, 2'd0));
        dm_accept();
        scan_dr(5'h11, 41, dmi_word(7'h06, 32'h0, 2'd2), d);
        chk("busy_cap", d, dmi_word(7'h05, 32'hDEADBEEF, 2'd3));
        chk("busy_drop", 64'({busy, dmi_rsp_ready, dmi_req_addr, dmi_req_op}), 64'({1'b1, 1'b1, 7'h05, 2'd1}));
        scan_dr(5'h10, 32, 64'h0, d);
        chk("dtmcs_busy", d, 64'h1C71);
        dm_respond(32'h12345678, 2'd0);
        scan_dr(5'h11, 41, dmi_word(7'h06, 32'hAA, 2'd2), d);
        chk("sticky_cap", d, dmi_word(7'h05, 32'h12345678, 2'd3));
        chk("sticky_ignore", 64'(busy), 64'h0);
        scan_dr(5'h10, 32, 64'h10000, d);
        chk("dtmcs_pre_reset", d, 64'h1C71);
        scan_dr(5'h11, 41, dmi_word(7'h06, 32'hAA, 2'd2), d);
        chk("after_dmireset_cap", d, dmi_word(7'h05, 32'h12345678, 2'd0));
        chk("after_dmireset_req", 64'({busy, dmi_req_addr, dmi_req_data, dmi_req_op}), 64'({1'b1, 7'h06, 32'hAA, 2'd2}));
        tick();
        dm_accept();
        dm_respond(32'h0, 2'd2);

        scan_dr(5'h11, 41, dmi_word(7'h07, 32'h0, 2'd1), d);
        chk("failed_cap", d, dmi_word(7'h06, 32'h0, 2'd2));
        chk("failed_ignore", 64'(busy), 64'h0);
        scan_dr(5'h10, 32, 64'h10000, d);
        chk("dtmcs_failed", d, 64'h1871);
        scan_dr(5'h10, 32, 64'h0, d);
        chk("dtmcs_cleared", d, 64'h1071);

        scan_dr(5'h11, 41, dmi_word(7'h08, 32'h55, 2'd2), d);
        chk("hr_cap", d, dmi_word(7'h06, 32'h0, 2'd0));
        chk("hr_in_req", 64'(dmi_req_valid), 64'h1);
        scan_dr(5'h10, 32, 64'h20000, d);
        chk("hr_dtmcs", d, 64'h1071);
        chk("hr_pulse", 64'({dmi_req_valid, dmi_rsp_ready, busy, dmi_hard_reset}), 64'b0001);
        tick();
        chk("hr_pulse_end", 64'({dmi_hard_reset, busy}), 64'h0);

        scan_dr(5'h11, 41, dmi_word(7'h09, 32'h0, 2'd1), d);
        chk("rst_mid_cap", d, dmi_word(7'h08, 32'h0, 2'd0));
        dm_accept();
        chk("rst_mid_rsp", 64'(dmi_rsp_ready), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", 64'({dmi_req_valid, dmi_rsp_ready, busy, dmi_hard_reset, dmi_req_addr, dmi_req_data, dmi_req_op}), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        scan_dr(5'h11, 41, 64'h0, d);
        chk("post_rst_dmi", d, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
